// File: rtl/fft_mag_framer_pkg.sv
// Shared defaults and FSM encodings for the FFT magnitude framer and the LCD top.
// The bin/frame counter widths are derived from these in the framer itself.
package fft_mag_framer_pkg;

  localparam int DEF_FFT_LEN = 128;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_OUT_W   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    SKIP = 2'd2
  } state_t;

  // Width of a counter that must hold 0..v-1, never narrower than one bit.
  function automatic int cnt_w(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/fft_mag_framer_if.sv
// Streaming bundle between FFT core, magnitude framer and the LCD FIFO controller.
// master = the environment around the framer, slave = the framer itself.
interface fft_mag_framer_if #(
  parameter int DATA_W = 16,
  parameter int OUT_W  = 16
);
  logic signed [DATA_W-1:0] src_real;
  logic signed [DATA_W-1:0] src_imag;
  logic                     src_sop;
  logic                     src_eop;
  logic                     src_valid;
  logic                     src_ready;
  logic [OUT_W-1:0]         fft_data;
  logic                     fft_sop;
  logic                     fft_eop;
  logic                     fft_valid;
  logic                     frame_err;

  modport master (
    output src_real, src_imag, src_sop, src_eop, src_valid,
    input  src_ready, fft_data, fft_sop, fft_eop, fft_valid, frame_err
  );

  modport slave (
    input  src_real, src_imag, src_sop, src_eop, src_valid,
    output src_ready, fft_data, fft_sop, fft_eop, fft_valid, frame_err
  );
endinterface

// File: rtl/fft_mag_calc.sv
// Three-stage magnitude estimate: |re|,|im| -> max/min -> max + min/4 + min/8,
// then right shift and saturate. sop/eop/valid travel alongside the data.
module fft_mag_calc #(
  parameter int DATA_W = 16,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic signed [DATA_W-1:0] re_i,
  input  logic signed [DATA_W-1:0] im_i,
  input  logic                     valid_i,
  input  logic                     sop_i,
  input  logic                     eop_i,
  output logic [OUT_W-1:0]         mag_o,
  output logic                     valid_o,
  output logic                     sop_o,
  output logic                     eop_o
);

  localparam int MW = (DATA_W + 1 > OUT_W) ? DATA_W + 1 : OUT_W;
  localparam logic [MW-1:0] OUT_MAX = MW'({OUT_W{1'b1}});

  // Two's-complement negate in unsigned arithmetic so the most negative
  // input lands on 2^(DATA_W-1) instead of wrapping.
  function automatic logic [DATA_W-1:0] abs_u(input logic [DATA_W-1:0] x);
    return x[DATA_W-1] ? (~x + 1'b1) : x;
  endfunction

  logic [DATA_W-1:0] a_q, b_q;
  logic [DATA_W-1:0] mx_q, mn_q;
  logic [OUT_W-1:0]  mag_q, mag_d;
  logic [2:0]        vld_q, sop_q, eop_q;

  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   sum_sh;
  logic [MW-1:0]     sum_ext;

  always_comb begin
    sum     = {1'b0, mx_q} + (DATA_W+1)'(mn_q >> 2) + (DATA_W+1)'(mn_q >> 3);
    sum_sh  = sum >> SHIFT;
    sum_ext = MW'(sum_sh);
    mag_d   = (sum_ext > OUT_MAX) ? {OUT_W{1'b1}} : OUT_W'(sum_ext);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q   <= '0;
      b_q   <= '0;
      mx_q  <= '0;
      mn_q  <= '0;
      mag_q <= '0;
      vld_q <= '0;
      sop_q <= '0;
      eop_q <= '0;
    end else begin
      a_q   <= abs_u(re_i);
      b_q   <= abs_u(im_i);
      mx_q  <= (a_q >= b_q) ? a_q : b_q;
      mn_q  <= (a_q >= b_q) ? b_q : a_q;
      mag_q <= mag_d;
      vld_q <= {vld_q[1:0], valid_i};
      sop_q <= {sop_q[1:0], sop_i & valid_i};
      eop_q <= {eop_q[1:0], eop_i & valid_i};
    end
  end

  assign mag_o   = mag_q;
  assign valid_o = vld_q[2];
  assign sop_o   = sop_q[2];
  assign eop_o   = eop_q[2];

endmodule

// File: rtl/fft_mag_framer.sv
// Turns the FFT core's complex bin stream into the 16-bit magnitude stream for
// the LCD path, keeping only the positive half and 1 of every FRAME_DIV frames.
module fft_mag_framer
  import fft_mag_framer_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int OUT_W     = DEF_OUT_W,
  parameter int FFT_LEN   = DEF_FFT_LEN,
  parameter int HALF_ONLY = 1,
  parameter int FRAME_DIV = 4,
  parameter int SHIFT     = 0
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  fft_mag_framer_if.slave  io
);

  localparam int BW   = $clog2(FFT_LEN) + 1;
  localparam int FW   = cnt_w(FRAME_DIV);
  localparam int HALF = FFT_LEN / 2;

  localparam logic [BW-1:0] LAST_BIN  = BW'(FFT_LEN - 1);
  localparam logic [BW-1:0] HALF_BIN  = BW'(HALF);
  localparam logic [BW-1:0] HALF_LAST = BW'(HALF - 1);
  localparam logic [FW-1:0] FCNT_MAX  = FW'(FRAME_DIV - 1);

  state_t        state_q, state_d;
  logic [BW-1:0] bin_cnt_q, bin_cnt_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic          err_q, err_d;
  logic          ready_q;

  logic          fwd, fwd_sop, fwd_eop, last_bin;

  always_comb begin
    state_d     = state_q;
    bin_cnt_d   = bin_cnt_q;
    frame_cnt_d = frame_cnt_q;
    err_d       = 1'b0;
    fwd         = 1'b0;
    fwd_sop     = 1'b0;
    fwd_eop     = 1'b0;
    last_bin    = 1'b0;

    if (io.src_valid) begin
      if (io.src_sop) begin
        // Any sop restarts framing, even mid-frame; the old frame is abandoned.
        err_d       = (state_q != IDLE) || io.src_eop;
        frame_cnt_d = (frame_cnt_q == FCNT_MAX) ? '0 : frame_cnt_q + FW'(1);
        bin_cnt_d   = BW'(1);
        fwd         = (frame_cnt_q == '0);
        fwd_sop     = 1'b1;
        fwd_eop     = io.src_eop || ((HALF_ONLY != 0) && (HALF_LAST == '0));
        if (io.src_eop || (LAST_BIN == '0)) begin
          state_d   = IDLE;
          bin_cnt_d = '0;
        end else begin
          state_d = fwd ? PASS : SKIP;
        end
      end else if (state_q == IDLE) begin
        err_d = 1'b1;
      end else begin
        last_bin  = (bin_cnt_q == LAST_BIN);
        fwd       = (state_q == PASS) && ((HALF_ONLY == 0) || (bin_cnt_q < HALF_BIN));
        fwd_eop   = io.src_eop || ((HALF_ONLY != 0) && (bin_cnt_q == HALF_LAST));
        err_d     = (io.src_eop != last_bin);
        bin_cnt_d = bin_cnt_q + BW'(1);
        if (io.src_eop || last_bin) begin
          state_d   = IDLE;
          bin_cnt_d = '0;
        end
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      bin_cnt_q   <= '0;
      frame_cnt_q <= '0;
      err_q       <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      bin_cnt_q   <= bin_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      err_q       <= err_d;
      ready_q     <= 1'b1;
    end
  end

  assign io.src_ready = ready_q;
  assign io.frame_err = err_q;

  fft_mag_calc #(
    .DATA_W (DATA_W),
    .OUT_W  (OUT_W),
    .SHIFT  (SHIFT)
  ) u_calc (
    .clk_i   (sys_clk),
    .rst_i   (sys_rst),
    .re_i    (io.src_real),
    .im_i    (io.src_imag),
    .valid_i (fwd),
    .sop_i   (fwd_sop),
    .eop_i   (fwd_eop),
    .mag_o   (io.fft_data),
    .valid_o (io.fft_valid),
    .sop_o   (io.fft_sop),
    .eop_o   (io.fft_eop)
  );

endmodule

// File: tb/tb_fft_mag_framer.sv
// Scoreboard bench for fft_mag_framer with default parameters (FRAME_DIV=4,
// HALF_ONLY=1, SHIFT=0); each scenario starts from reset so frame 0 is passed.
module tb_fft_mag_framer;

  localparam int FFT_LEN = 128;
  localparam int HALF    = FFT_LEN / 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fft_mag_framer_if #(.DATA_W(16), .OUT_W(16)) bus ();

  fft_mag_framer dut (
    .sys_clk (clk),
    .sys_rst (rst),
    .io      (bus)
  );

  typedef struct packed {
    logic [15:0] d;
    logic        s;
    logic        e;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_x;

  int n_vec        = 0;
  int n_miss       = 0;
  int err_pulses   = 0;
  int n_out        = 0;
  int cyc          = 0;
  int first_out_cyc = -1;
  int sop_in_cyc   = -1;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.frame_err) err_pulses++;
    if (bus.fft_valid) begin
      n_out++;
      if (bus.fft_sop && first_out_cyc < 0) first_out_cyc = cyc;
      n_vec++;
      if (sbq.size() == 0) begin
        n_miss++;
        $display("FAIL unexpected_beat: got data=%0d sop=%0b eop=%0b, required no output",
                 bus.fft_data, bus.fft_sop, bus.fft_eop);
      end else begin
        mon_x = sbq.pop_front();
        if ({bus.fft_data, bus.fft_sop, bus.fft_eop} !== {mon_x.d, mon_x.s, mon_x.e}) begin
          n_miss++;
          $display("FAIL out_beat: got data=%0d sop=%0b eop=%0b, required data=%0d sop=%0b eop=%0b",
                   bus.fft_data, bus.fft_sop, bus.fft_eop, mon_x.d, mon_x.s, mon_x.e);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  function automatic int mag_model(input int re, input int im);
    int a, b, mx, mn, m;
    a  = (re < 0) ? -re : re;
    b  = (im < 0) ? -im : im;
    mx = (a > b) ? a : b;
    mn = (a > b) ? b : a;
    m  = mx + mn / 4 + mn / 8;
    return (m > 65535) ? 65535 : m;
  endfunction

  function automatic int rnd16();
    return int'($urandom_range(65535)) - 32768;
  endfunction

  task automatic idle_inputs();
    bus.src_real  = '0;
    bus.src_imag  = '0;
    bus.src_sop   = 1'b0;
    bus.src_eop   = 1'b0;
    bus.src_valid = 1'b0;
  endtask

  task automatic send_beat(input int re, input int im, input bit sop, input bit eop,
                           input bit fwd, input int ed, input bit esop, input bit eeop);
    exp_t x;
    bus.src_real  = 16'(re);
    bus.src_imag  = 16'(im);
    bus.src_sop   = sop;
    bus.src_eop   = eop;
    bus.src_valid = 1'b1;
    if (sop) sop_in_cyc = cyc;
    if (fwd) begin
      x.d = 16'(ed);
      x.s = esop;
      x.e = eeop;
      sbq.push_back(x);
    end
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic send_frame(input int len, input bit passed);
    int re, im;
    for (int i = 0; i < len; i++) begin
      re = rnd16();
      im = rnd16();
      send_beat(re, im, i == 0, i == len - 1, passed && (i < HALF), mag_model(re, im),
                i == 0, (i == HALF - 1) || (i == len - 1));
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 100 && sbq.size() != 0; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    n_vec++;
    if (sbq.size() != 0) begin
      n_miss++;
      $display("FAIL %s_drain: %0d expected beats never came out, required 0", name, sbq.size());
      sbq.delete();
    end
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    idle_inputs();
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({bus.fft_valid, bus.fft_sop, bus.fft_eop, bus.frame_err, bus.src_ready, bus.fft_data} !== 21'd0) begin
      n_miss++;
      $display("FAIL reset_outputs: got valid=%0b sop=%0b eop=%0b err=%0b ready=%0b data=%0d, required all 0",
               bus.fft_valid, bus.fft_sop, bus.fft_eop, bus.frame_err, bus.src_ready, bus.fft_data);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (bus.src_ready !== 1'b1) begin
      n_miss++;
      $display("FAIL ready_after_reset: got %0b, required 1", bus.src_ready);
    end
  endtask

  task automatic test_single_frame();
    int e0, o0;
    do_reset(2);
    e0 = err_pulses;
    o0 = n_out;
    first_out_cyc = -1;
    for (int i = 0; i < FFT_LEN; i++)
      send_beat(3000, -4000, i == 0, i == FFT_LEN - 1, i < HALF, 5125, i == 0, i == HALF - 1);
    drain("single");
    n_vec++;
    if (first_out_cyc - sop_in_cyc !== 3) begin
      n_miss++;
      $display("FAIL single_latency: got %0d cycles, required 3", first_out_cyc - sop_in_cyc);
    end
    n_vec++;
    if (n_out - o0 !== HALF) begin
      n_miss++;
      $display("FAIL single_count: got %0d beats, required %0d", n_out - o0, HALF);
    end
    n_vec++;
    if (err_pulses - e0 !== 0) begin
      n_miss++;
      $display("FAIL single_err: got %0d pulses, required 0", err_pulses - e0);
    end
  endtask

  task automatic test_extremes();
    int xre[5] = '{-32768, 32767, 0, -32768, 3000};
    int xim[5] = '{-32768, 0, 0, 32767, -4000};
    int xm[5]  = '{45056, 32767, 0, 45054, 5125};
    int re, im, ed;
    do_reset(2);
    for (int i = 0; i < FFT_LEN; i++) begin
      if (i < 5) begin
        re = xre[i]; im = xim[i]; ed = xm[i];
      end else begin
        re = rnd16(); im = rnd16(); ed = mag_model(re, im);
      end
      send_beat(re, im, i == 0, i == FFT_LEN - 1, i < HALF, ed, i == 0, i == HALF - 1);
    end
    drain("extremes");
  endtask

  task automatic test_decimation();
    int e0, o0;
    do_reset(2);
    e0 = err_pulses;
    o0 = n_out;
    for (int f = 0; f < 8; f++) send_frame(FFT_LEN, (f % 4) == 0);
    drain("decim");
    n_vec++;
    if (n_out - o0 !== 2 * HALF) begin
      n_miss++;
      $display("FAIL decim_count: got %0d beats, required %0d", n_out - o0, 2 * HALF);
    end
    n_vec++;
    if (err_pulses - e0 !== 0) begin
      n_miss++;
      $display("FAIL decim_err: got %0d pulses, required 0", err_pulses - e0);
    end
  endtask

  task automatic test_early_eop();
    int e0;
    do_reset(2);
    e0 = err_pulses;
    send_frame(40, 1'b1);
    drain("early_eop");
    n_vec++;
    if (err_pulses - e0 !== 1) begin
      n_miss++;
      $display("FAIL early_eop_err: got %0d pulses, required 1", err_pulses - e0);
    end
    // Second frame is frame 1 of 4: accepted without error but not forwarded.
    send_frame(FFT_LEN, 1'b0);
    drain("after_early");
    n_vec++;
    if (err_pulses - e0 !== 1) begin
      n_miss++;
      $display("FAIL after_early_err: got %0d pulses, required 1", err_pulses - e0);
    end
  endtask

  task automatic test_sop_inject();
    int e0, o0, re, im, j;
    do_reset(2);
    send_frame(FFT_LEN, 1'b1);
    send_frame(FFT_LEN, 1'b0);
    send_frame(FFT_LEN, 1'b0);
    e0 = err_pulses;
    o0 = n_out;
    // Frame 3 is skipped; its sop at beat 20 starts frame 4 (passed).
    for (int i = 0; i < 20 + FFT_LEN; i++) begin
      re = rnd16();
      im = rnd16();
      j  = i - 20;
      send_beat(re, im, (i == 0) || (j == 0), j == FFT_LEN - 1,
                (j >= 0) && (j < HALF), mag_model(re, im), j == 0, j == HALF - 1);
    end
    drain("sop_inject");
    n_vec++;
    if (err_pulses - e0 !== 1) begin
      n_miss++;
      $display("FAIL sop_inject_err: got %0d pulses, required 1", err_pulses - e0);
    end
    n_vec++;
    if (n_out - o0 !== HALF) begin
      n_miss++;
      $display("FAIL sop_inject_count: got %0d beats, required %0d", n_out - o0, HALF);
    end
  endtask

  task automatic test_back_to_back_reset();
    int e0, o0, re, im;
    do_reset(2);
    e0 = err_pulses;
    o0 = n_out;
    for (int i = 0; i < 30; i++) begin
      re = rnd16();
      im = rnd16();
      send_beat(re, im, i == 0, 1'b0, i < 28, mag_model(re, im), i == 0, 1'b0);
    end
    bus.src_real  = 16'sd1000;
    bus.src_imag  = 16'sd1000;
    bus.src_valid = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_inputs();
    @(negedge clk);
    n_vec++;
    if ({bus.fft_valid, bus.fft_sop, bus.fft_eop, bus.frame_err, bus.src_ready, bus.fft_data} !== 21'd0) begin
      n_miss++;
      $display("FAIL midreset_outputs: got valid=%0b sop=%0b eop=%0b err=%0b ready=%0b data=%0d, required all 0",
               bus.fft_valid, bus.fft_sop, bus.fft_eop, bus.frame_err, bus.src_ready, bus.fft_data);
    end
    drain("midreset");
    n_vec++;
    if (n_out - o0 !== 28) begin
      n_miss++;
      $display("FAIL midreset_count: got %0d beats, required 28", n_out - o0);
    end
    send_frame(FFT_LEN, 1'b1);
    drain("post_reset");
    n_vec++;
    if (err_pulses - e0 !== 0) begin
      n_miss++;
      $display("FAIL midreset_err: got %0d pulses, required 0", err_pulses - e0);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single_frame();
    test_extremes();
    test_decimation();
    test_early_eop();
    test_sop_inject();
    test_back_to_back_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
